// File: rtl/alu_pkg.sv
// Shared constants for the ALU scheduler: opcode encodings, flag bit
// positions inside the Z,V,N vector, and requester ids.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Requester ids: pipeline execute stage and auxiliary address/debug port.
  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter. A lone valid requester is always granted. On contention:
//   ALU_ARB_RR_EN defined   -> round-robin, grant the id that did not win last.
//   ALU_ARB_RR_EN undefined -> fixed priority, requester 0 always wins.
// en low forces no grant (used to block issue while the pipe is stalled).
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

`ifndef ALU_ARB_RR_EN
  // The pointer is still tracked by the parent but has no effect here.
  logic unused_last;
  assign unused_last = last;
`endif

  // Grant selection from the current valids and the round-robin pointer.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
        grant = (last == REQ_AUX) ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester scheduler in front of a shared combinational ALU.
// Stage S1 registers the granted operands onto alu_*, stage S2 registers the
// ALU result onto the tagged response channel. Owns the Z,V,N flag register,
// which only requester 0 (REQ_EX) updates.
// Optional build macro: ALU_ARB_RR_EN selects round-robin arbitration on
// contention; without it requester 0 has fixed priority.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Requests may be held or withdrawn by the requester; ready never
// depends on the requester's own operands. rsp_valid stays high with
// rsp_id/rsp_data stable until the edge where rsp_ready is also high.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_zvn,
  input  logic [2:0]        alu_fwe,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        flags
);

  logic       adv;
  logic [1:0] grant;
  logic       accept;
  logic       s1_valid;
  logic       s1_id;
  logic       last;

  // The whole pipe advances together unless a held response is not taken.
  assign adv = ~rsp_valid | rsp_ready;

  rr_arbiter2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last),
    .en    (adv),
    .grant (grant)
  );

  assign req0_ready = adv & grant[0];
  assign req1_ready = adv & grant[1];
  assign accept     = req0_ready | req1_ready;

  // S1 issue register: loads the granted request, or a bubble. Operands are
  // held on a bubble so the ALU inputs do not toggle needlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= REQ_EX;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_op   <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (req1_ready) begin
        s1_id   <= REQ_AUX;
        alu_in1 <= req1_a;
        alu_in2 <= req1_b;
        alu_op  <= req1_op;
      end else if (req0_ready) begin
        s1_id   <= REQ_EX;
        alu_in1 <= req0_a;
        alu_in2 <= req0_b;
        alu_op  <= req0_op;
      end
    end
  end

  // S2 response register: captures the ALU result of the S1 entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= REQ_EX;
      rsp_data  <= '0;
    end else if (adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id   <= s1_id;
        rsp_data <= alu_out;
      end
    end
  end

  // Architectural flags: only REQ_EX results write, and only enabled bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (adv && s1_valid && (s1_id == REQ_EX)) begin
      flags <= (alu_fwe & alu_zvn) | (~alu_fwe & flags);
    end
  end

  // Round-robin pointer: id of the most recent accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_AUX;
    end else if (accept) begin
      last <= req1_ready;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Provides a reference ALU model on the alu_* port,
// a negedge monitor that pushes expected {id,data} on every accept and pops
// on every delivered response, and directed scenario tasks.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int OW = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_in1, alu_in2, alu_out, rsp_data;
  logic [2:0]    alu_zvn, alu_fwe, flags;
  logic          rsp_valid, rsp_ready, rsp_id;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [21:0] mon_m;
  logic [16:0] mon_exp;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zvn(alu_zvn), .alu_fwe(alu_fwe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .flags(flags)
  );

  // Reference ALU: returns {fwe[2:0], zvn[2:0], result[15:0]}.
  function automatic logic [21:0] alu_calc(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic [2:0]  we;
    logic        v;
    s = '0; r = '0; we = 3'b000; v = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) s = {a[15], a} + {b[15], b};
        else              s = {a[15], a} - {b[15], b};
        v  = s[16] ^ s[15];
        r  = v ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
        we = 3'b111;
      end
      OP_XOR: begin r = a ^ b; we = 3'b100; end
      OP_SLL: begin r = a << b[3:0]; we = 3'b100; end
      OP_SRA: begin r = $signed(a) >>> b[3:0]; we = 3'b100; end
      OP_ROR: begin r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]})); we = 3'b100; end
      OP_RED, OP_PADDSB, OP_LW, OP_SW: r = a + b;
      OP_LLB: r = {b[15:8], a[7:0]};
      OP_LHB: r = {a[7:0], b[7:0]};
      default: r = '0;
    endcase
    return {we, (r == 16'h0000), v, r[15], r};
  endfunction

  assign {alu_fwe, alu_zvn, alu_out} = alu_calc(alu_op, alu_in1, alu_in2);

  // Driver tasks
  task automatic drive_req(input logic id, input logic vld, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = vld; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = vld; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Call at posedge+1; returns at accept edge+1.
  task automatic send(input logic id, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    drive_req(id, 1'b1, op, a, b);
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout id=%0d ready=0 required=1", id);
    end
    @(posedge clk); #1;
    drive_req(id, 1'b0, op, a, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== 18'h0) begin
      n_err++; $display("FAIL reset_rsp got v=%b id=%b d=%h required 0", rsp_valid, rsp_id, rsp_data);
    end
    n_vec++;
    if ({alu_in1, alu_in2, alu_op} !== 36'h0) begin
      n_err++; $display("FAIL reset_alu got %h %h %h required 0", alu_in1, alu_in2, alu_op);
    end
    n_vec++;
    if (flags !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b required 000", flags);
    end
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready got %b required 00", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, OP_ADD, 16'h7000, 16'h2000);
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL add_early rsp_valid got %b required 0", rsp_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'h7FFF}) begin
      n_err++; $display("FAIL add_rsp got v=%b id=%b d=%h required v=1 id=0 d=7fff", rsp_valid, rsp_id, rsp_data);
    end
    n_vec++;
    if (flags !== 3'b010) begin
      n_err++; $display("FAIL add_flags got %b required 010", flags);
    end
  endtask

  task automatic test_aux_sub();
    @(posedge clk); #1;
    send(1'b0, OP_SUB, 16'h0000, 16'h0001);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({rsp_data, flags} !== {16'hFFFF, 3'b001}) begin
      n_err++; $display("FAIL neg_sub got d=%h f=%b required d=ffff f=001", rsp_data, flags);
    end
    @(posedge clk); #1;
    send(1'b1, OP_SUB, 16'h0005, 16'h0005);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL aux_rsp got v=%b id=%b d=%h required v=1 id=1 d=0000", rsp_valid, rsp_id, rsp_data);
    end
    n_vec++;
    if (flags !== 3'b001) begin
      n_err++; $display("FAIL aux_flags got %b required 001", flags);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    drive_req(1'b1, 1'b1, OP_XOR, 16'h00F0, 16'h0011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef ALU_ARB_RR_EN
      exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_rdy = 2'b01;
`endif
      n_vec++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        n_err++; $display("FAIL contention_%0d ready got %b required %b", i, {req1_ready, req0_ready}, exp_rdy);
      end
      @(posedge clk); #1;
      req0_a = 16'(i + 2);
      req1_a = 16'(i + 7);
    end
    drive_req(1'b0, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OP_ADD, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] h1, h2;
    logic [3:0]  hop;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, OP_XOR, 16'h00FF, 16'h0F0F);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, OP_ADD, 16'h0003, 16'h0004);
    drive_req(1'b1, 1'b1, OP_SUB, 16'h0009, 16'h0002);
    @(negedge clk);
    h1 = alu_in1; h2 = alu_in2; hop = alu_op;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'h0FF0}) begin
        n_err++; $display("FAIL bp_hold_%0d got v=%b id=%b d=%h required v=1 id=0 d=0ff0", k, rsp_valid, rsp_id, rsp_data);
      end
      n_vec++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_err++; $display("FAIL bp_ready_%0d got %b required 00", k, {req1_ready, req0_ready});
      end
      n_vec++;
      if ({alu_in1, alu_in2, alu_op} !== {h1, h2, hop}) begin
        n_err++; $display("FAIL bp_alu_%0d got %h %h %h required %h %h %h", k, alu_in1, alu_in2, alu_op, h1, h2, hop);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ((req0_ready ^ req1_ready) !== 1'b1 || rsp_data !== 16'h0FF0) begin
      n_err++; $display("FAIL bp_release got rdy=%b d=%h required one ready d=0ff0", {req1_ready, req0_ready}, rsp_data);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_ADD, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OP_ADD, 16'h0, 16'h0);
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_one_beat rsp_valid got %b required 0", rsp_valid);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_flag_write_enable();
    @(posedge clk); #1;
    send(1'b0, OP_SUB, 16'h1234, 16'h1234);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({rsp_data, flags} !== {16'h0000, 3'b100}) begin
      n_err++; $display("FAIL sub_zero got d=%h f=%b required d=0000 f=100", rsp_data, flags);
    end
    @(posedge clk); #1;
    send(1'b0, OP_LLB, 16'h0034, 16'hAB00);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({rsp_data, flags} !== {16'hAB34, 3'b100}) begin
      n_err++; $display("FAIL llb got d=%h f=%b required d=ab34 f=100", rsp_data, flags);
    end
    @(posedge clk); #1;
    send(1'b0, 4'hC, 16'h1234, 16'h5678);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_data, flags} !== {1'b1, 16'h0000, 3'b100}) begin
      n_err++; $display("FAIL op_c got v=%b d=%h f=%b required v=1 d=0000 f=100", rsp_valid, rsp_data, flags);
    end
    @(posedge clk); #1;
    send(1'b0, OP_SUB, 16'h0000, 16'h0001);
    @(posedge clk); #1;
    send(1'b0, OP_XOR, 16'h0001, 16'h0001);
    @(negedge clk); @(negedge clk);
    n_vec++;
    if (flags !== 3'b101) begin
      n_err++; $display("FAIL xor_zonly got %b required 101", flags);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)));
      @(negedge clk);
      n_vec++;
      if (req0_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_%0d got %b required 1", i, req0_ready);
      end
      if (i >= 2) begin
        n_vec++;
        if (rsp_valid !== 1'b1) begin
          n_err++; $display("FAIL b2b_rsp_%0d rsp_valid got %b required 1", i, rsp_valid);
        end
      end
      @(posedge clk); #1;
    end
    drive_req(1'b0, 1'b0, OP_ADD, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, OP_SUB, 16'h0000, 16'h0001);
    send(1'b0, OP_ADD, 16'h0002, 16'h0002);
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_data, flags} !== {1'b1, 16'hFFFF, 3'b001}) begin
      n_err++; $display("FAIL rmid_pre got v=%b d=%h f=%b required v=1 d=ffff f=001", rsp_valid, rsp_data, flags);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rsp_valid, rsp_data, flags, alu_in1} !== 36'h0) begin
      n_err++; $display("FAIL rmid_reset got v=%b d=%h f=%b in1=%h required 0", rsp_valid, rsp_data, flags, alu_in1);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL rmid_stale_%0d rsp_valid got %b required 0", k, rsp_valid);
      end
    end
  endtask

  initial begin
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;

    // Scoreboard monitor: push on accept, pop and compare on delivery.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (req0_valid && req0_ready) begin
            mon_m = alu_calc(req0_op, req0_a, req0_b);
            exp_q.push_back({REQ_EX, mon_m[15:0]});
          end
          if (req1_valid && req1_ready) begin
            mon_m = alu_calc(req1_op, req1_a, req1_b);
            exp_q.push_back({REQ_AUX, mon_m[15:0]});
          end
          if (rsp_valid && rsp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL sb_unexpected got id=%b d=%h required none", rsp_id, rsp_data);
            end else begin
              mon_exp = exp_q.pop_front();
              if ({rsp_id, rsp_data} !== mon_exp) begin
                n_err++; $display("FAIL sb_rsp got id=%b d=%h required id=%b d=%h", rsp_id, rsp_data, mon_exp[16], mon_exp[15:0]);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_add();
    test_aux_sub();
    test_contention();
    test_backpressure();
    test_flag_write_enable();
    test_back_to_back();
    test_reset_mid();

    @(posedge clk); #1;
    send(1'b1, OP_ADD, 16'h0010, 16'h0020);
    repeat (4) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
